// File: rtl/tx_controller.sv
// tx_controller: control FSM for the UART transmitter datapath.
//
// Sequences a byte through the tx datapath: data-register load, shift-register
// load, start-bit launch and the data-bit shift loop. Mealy machine: every output
// is a single-cycle strobe decoded from the current state plus the inputs, and at
// most one strobe is high in any cycle.
//
// Ports
//   clk             in  clock, all state updates on posedge
//   rst_b           in  synchronous active-low reset
//   byteReady       in  host: data register holds a byte for the shift register
//   transmitByte    in  host: begin transmitting the loaded byte
//   bitCountMax     in  datapath: bit counter reached the final bit
//   loadDataReg     in  host: request load of the data register
//   clear           out strobe: clear bit counter / end of frame
//   shift           out strobe: shift the tx shift register one bit
//   start           out strobe: launch the start bit
//   loadShiftReg    out strobe: copy data register into shift register
//   sigLoadDataReg  out strobe: load data register from host bus
module tx_controller #(
    parameter int unsigned               stateCount = 3,
    parameter logic [stateCount-1:0]     idle       = 3'b001,
    parameter logic [stateCount-1:0]     waiting    = 3'b010,
    parameter logic [stateCount-1:0]     sending    = 3'b100
) (
    input  logic clk,
    input  logic rst_b,
    input  logic byteReady,
    input  logic transmitByte,
    input  logic bitCountMax,
    input  logic loadDataReg,
    output logic clear,
    output logic shift,
    output logic start,
    output logic loadShiftReg,
    output logic sigLoadDataReg
);

    // One-hot state register; name is fixed because it is probed from outside.
    logic [stateCount-1:0] currentState;
    logic [stateCount-1:0] nextState;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            currentState <= idle;
        end else begin
            currentState <= nextState;
        end
    end

    always_comb begin
        nextState      = currentState;
        clear          = 1'b0;
        shift          = 1'b0;
        start          = 1'b0;
        loadShiftReg   = 1'b0;
        sigLoadDataReg = 1'b0;

        if (!rst_b) begin
            // Strobes are held low for the whole reset; an aborted frame never
            // sees clear.
            nextState = idle;
        end else begin
            case (currentState)
                idle: begin
                    // A data-register load wins over handing the byte onward.
                    if (loadDataReg) begin
                        sigLoadDataReg = 1'b1;
                    end else if (byteReady) begin
                        loadShiftReg = 1'b1;
                        nextState    = waiting;
                    end
                end
                waiting: begin
                    if (transmitByte) begin
                        start     = 1'b1;
                        nextState = sending;
                    end
                end
                sending: begin
                    if (bitCountMax) begin
                        clear     = 1'b1;
                        nextState = idle;
                    end else begin
                        shift = 1'b1;
                    end
                end
                default: begin
                    // Illegal encoding: stay silent and recover.
                    nextState = idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_controller.sv
// Self-checking bench for tx_controller.
// A state-number model (0 idle, 1 waiting, 2 sending) predicts the strobes and
// state every cycle; directed steps add literal expectations on top.
module tb_tx_controller;

    logic clk;
    logic rst_b;
    logic byteReady;
    logic transmitByte;
    logic bitCountMax;
    logic loadDataReg;
    logic clear;
    logic shift;
    logic start;
    logic loadShiftReg;
    logic sigLoadDataReg;

    int total = 0;
    int bad   = 0;

    tx_controller dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .byteReady      (byteReady),
        .transmitByte   (transmitByte),
        .bitCountMax    (bitCountMax),
        .loadDataReg    (loadDataReg),
        .clear          (clear),
        .shift          (shift),
        .start          (start),
        .loadShiftReg   (loadShiftReg),
        .sigLoadDataReg (sigLoadDataReg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    int m_state = 0;
    bit m_valid = 1'b0;

    // Strobe vector order: {clear, shift, start, loadShiftReg, sigLoadDataReg}
    function automatic logic [4:0] model_out(input int st);
        logic [4:0] o;
        o = 5'b0;
        if (rst_b) begin
            if (st == 0) begin
                if (loadDataReg)    o = 5'b00001;
                else if (byteReady) o = 5'b00010;
            end else if (st == 1) begin
                if (transmitByte)   o = 5'b00100;
            end else begin
                o = bitCountMax ? 5'b10000 : 5'b01000;
            end
        end
        return o;
    endfunction

    always @(posedge clk) begin
        if (!rst_b) begin
            m_state = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_state == 0 && byteReady && !loadDataReg) m_state = 1;
            else if (m_state == 1 && transmitByte)         m_state = 2;
            else if (m_state == 2 && bitCountMax)          m_state = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [4:0] act;
        logic [4:0] exp_o;
        logic [2:0] exp_s;
        act = {clear, shift, start, loadShiftReg, sigLoadDataReg};
        if (!rst_b || m_valid) begin
            exp_o = model_out(m_state);
            total = total + 1;
            if (act !== exp_o) begin
                bad = bad + 1;
                $display("FAIL strobes t=%0t got=%b want=%b", $time, act, exp_o);
            end
        end
        if (m_valid) begin
            exp_s = 3'b001 << m_state;
            total = total + 1;
            if (dut.currentState !== exp_s) begin
                bad = bad + 1;
                $display("FAIL state t=%0t got=%b want=%b", $time, dut.currentState, exp_s);
            end
        end
    end

    // ---------------- directed steps ----------------
    task automatic check(input string name, input logic [2:0] got, input logic [2:0] want);
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        byteReady    = 1'b0;
        transmitByte = 1'b0;
        bitCountMax  = 1'b0;
        loadDataReg  = 1'b0;
    endtask

    int starts;

    initial begin
        rst_b = 1'b0;
        clr_inputs();

        // 1: reset for 1.5 cycles
        @(negedge clk);
        check("reset_outs", {clear, shift, start}, 3'b000);
        check("reset_outs2", {1'b0, loadShiftReg, sigLoadDataReg}, 3'b000);
        #6;
        rst_b = 1'b1;
        check("reset_state", dut.currentState, 3'b001);

        // 2: idle -> waiting -> sending
        byteReady = 1'b1;
        @(negedge clk);
        check("idle_loadshift", {2'b0, loadShiftReg}, 3'b001);
        next_cycle();
        byteReady = 1'b0;
        check("to_waiting", dut.currentState, 3'b010);
        transmitByte = 1'b1;
        @(negedge clk);
        check("wait_start", {2'b0, start}, 3'b001);
        next_cycle();
        transmitByte = 1'b0;
        check("to_sending", dut.currentState, 3'b100);

        // 4: eight shifts then clear
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("send_shift", {clear, shift, start}, 3'b010);
            next_cycle();
        end
        bitCountMax = 1'b1;
        @(negedge clk);
        check("send_clear", {clear, shift, start}, 3'b100);
        next_cycle();
        bitCountMax = 1'b0;
        check("to_idle", dut.currentState, 3'b001);

        // 3: loadDataReg beats byteReady
        loadDataReg = 1'b1;
        byteReady   = 1'b1;
        @(negedge clk);
        check("prio_strobes", {1'b0, loadShiftReg, sigLoadDataReg}, 3'b001);
        next_cycle();
        clr_inputs();
        check("prio_state", dut.currentState, 3'b001);

        // 5: waiting ignores host loads; 1,0,1 on transmitByte gives one start
        byteReady = 1'b1;
        next_cycle();
        byteReady   = 1'b1;
        loadDataReg = 1'b1;
        @(negedge clk);
        check("wait_quiet", {start, loadShiftReg, sigLoadDataReg}, 3'b000);
        next_cycle();
        clr_inputs();
        check("wait_hold", dut.currentState, 3'b010);
        starts = 0;
        for (int i = 0; i < 3; i++) begin
            transmitByte = (i != 1);
            @(negedge clk);
            if (start) starts++;
            next_cycle();
        end
        transmitByte = 1'b0;
        check("one_start", starts[2:0], 3'd1);
        bitCountMax = 1'b1;
        next_cycle();
        bitCountMax = 1'b0;
        check("frame_end", dut.currentState, 3'b001);

        // 6: reset in the middle of a frame
        byteReady = 1'b1;
        next_cycle();
        byteReady    = 1'b0;
        transmitByte = 1'b1;
        next_cycle();
        transmitByte = 1'b0;
        check("pre_abort", dut.currentState, 3'b100);
        rst_b       = 1'b0;
        bitCountMax = 1'b1;
        @(negedge clk);
        check("abort_quiet", {clear, shift, start}, 3'b000);
        next_cycle();
        check("abort_state", dut.currentState, 3'b001);
        rst_b = 1'b1;
        clr_inputs();

        repeat (3) next_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
